// File: rtl/traffic_sensor_conditioner_if.sv
// Signal bundle between the raw road sensors and the traffic light controller inputs.
// master drives the raw detector lines; slave is the conditioner that produces the controller inputs.
interface traffic_sensor_conditioner_if;
  logic [3:0] loop_in;
  logic [3:0] siren_in;
  logic [1:0] TA;
  logic [1:0] TB;
  logic [1:0] TC;
  logic [1:0] TD;
  logic       VA;
  logic       VB;
  logic       VC;
  logic       VD;
  logic       emg_mode;
  logic [1:0] ER;
  logic       window_tick;

  modport master (
    output loop_in, siren_in,
    input  TA, TB, TC, TD, VA, VB, VC, VD, emg_mode, ER, window_tick
  );

  modport slave (
    input  loop_in, siren_in,
    output TA, TB, TC, TD, VA, VB, VC, VD, emg_mode, ER, window_tick
  );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Debounces raw loop and siren detectors, measures per-road traffic density per window,
// generates held vehicle-present flags and arbitrates sirens into one latched emergency road.
module traffic_sensor_conditioner #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned WINDOW     = 256,
  parameter int unsigned TH1        = 2,
  parameter int unsigned TH2        = 5,
  parameter int unsigned TH3        = 9,
  parameter int unsigned VHOLD      = 64,
  parameter int unsigned EMG_HOLD   = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  traffic_sensor_conditioner_if.slave  bus
);

  localparam int unsigned NLINE   = 8;
  localparam int unsigned NROAD   = 4;
  localparam int unsigned DW      = $clog2(DEB_CYCLES + 1);
  localparam int unsigned WW      = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned VW      = $clog2(VHOLD + 1);
  localparam int unsigned EW      = $clog2(EMG_HOLD + 1);
  localparam int unsigned CW      = 4;
  localparam int unsigned CNT_MAX = 15;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HOLD   = 2'd2
  } emg_state_e;

  // debounce: lines 0..3 are loops A..D, lines 4..7 are sirens A..D
  logic [NLINE-1:0]          raw_c;
  logic [NLINE-1:0]          deb_q, deb_d;
  logic [NLINE-1:0][DW-1:0]  dcnt_q, dcnt_d;
  logic [NROAD-1:0]          loop_c;
  logic [NROAD-1:0]          siren_c;

  // vehicle events and density
  logic [NROAD-1:0]          loop_dly_q, loop_dly_d;
  logic [NROAD-1:0]          ev_q, ev_d;
  logic [WW-1:0]             win_q, win_d;
  logic                      win_term_c;
  logic [NROAD-1:0][CW-1:0]  cnt_inc_c;
  logic [NROAD-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [NROAD-1:0][1:0]     dens_q, dens_d;
  logic                      tick_q, tick_d;

  // vehicle-present flags
  logic [NROAD-1:0][VW-1:0]  vh_q, vh_d;
  logic [NROAD-1:0]          v_q, v_d;

  // emergency arbitration
  emg_state_e                st_q, st_d;
  logic                      emg_q, emg_d;
  logic [1:0]                er_q, er_d;
  logic [EW-1:0]             ecnt_q, ecnt_d;

  function automatic logic [1:0] quantize(input logic [CW-1:0] c);
    logic [1:0] q;
    if (32'(c) < TH1)      q = 2'd0;
    else if (32'(c) < TH2) q = 2'd1;
    else if (32'(c) < TH3) q = 2'd2;
    else                   q = 2'd3;
    return q;
  endfunction

  function automatic logic [1:0] first_set(input logic [NROAD-1:0] s);
    logic [1:0] idx;
    if (s[0])      idx = 2'd0;
    else if (s[1]) idx = 2'd1;
    else if (s[2]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

  assign raw_c   = {bus.siren_in, bus.loop_in};
  assign loop_c  = deb_q[NROAD-1:0];
  assign siren_c = deb_q[NLINE-1:NROAD];

  // A line flips only after DEB_CYCLES consecutive samples disagree with it
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    for (int i = 0; i < NLINE; i++) begin
      if (raw_c[i] != deb_q[i]) begin
        if (dcnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Window counting; an event in the terminal cycle still lands in the closing window
  always_comb begin
    loop_dly_d = loop_c;
    ev_d       = loop_c & ~loop_dly_q;
    win_term_c = (win_q == WW'(WINDOW - 1));
    win_d      = win_term_c ? '0 : win_q + WW'(1);
    tick_d     = win_term_c;
    cnt_inc_c  = cnt_q;
    cnt_d      = cnt_q;
    dens_d     = dens_q;
    for (int r = 0; r < NROAD; r++) begin
      if (ev_q[r] && (cnt_q[r] != CW'(CNT_MAX))) begin
        cnt_inc_c[r] = cnt_q[r] + CW'(1);
      end
      if (win_term_c) begin
        dens_d[r] = quantize(cnt_inc_c[r]);
        cnt_d[r]  = '0;
      end else begin
        cnt_d[r]  = cnt_inc_c[r];
      end
    end
  end

  // Hold counter is kept preloaded while the loop is occupied, so it starts counting at the fall
  always_comb begin
    vh_d = vh_q;
    v_d  = v_q;
    for (int r = 0; r < NROAD; r++) begin
      if (loop_c[r]) begin
        vh_d[r] = VW'(VHOLD);
        v_d[r]  = 1'b1;
      end else if (vh_q[r] != '0) begin
        vh_d[r] = vh_q[r] - VW'(1);
        v_d[r]  = (vh_q[r] > VW'(1));
      end else begin
        vh_d[r] = '0;
        v_d[r]  = 1'b0;
      end
    end
  end

  // Emergency arbitration: fixed priority from IDLE only, no preemption once granted
  always_comb begin
    st_d   = st_q;
    emg_d  = emg_q;
    er_d   = er_q;
    ecnt_d = ecnt_q;
    case (st_q)
      S_IDLE: begin
        emg_d  = 1'b0;
        er_d   = 2'd0;
        ecnt_d = '0;
        if (|siren_c) begin
          st_d  = S_ACTIVE;
          emg_d = 1'b1;
          er_d  = first_set(siren_c);
        end
      end
      S_ACTIVE: begin
        if (!siren_c[er_q]) begin
          st_d   = S_HOLD;
          ecnt_d = EW'(EMG_HOLD);
        end
      end
      S_HOLD: begin
        if (siren_c[er_q]) begin
          st_d   = S_ACTIVE;
          ecnt_d = '0;
        end else if (ecnt_q <= EW'(1)) begin
          st_d   = S_IDLE;
          emg_d  = 1'b0;
          er_d   = 2'd0;
          ecnt_d = '0;
        end else begin
          ecnt_d = ecnt_q - EW'(1);
        end
      end
      default: begin
        st_d   = S_IDLE;
        emg_d  = 1'b0;
        er_d   = 2'd0;
        ecnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q      <= '0;
      dcnt_q     <= '0;
      loop_dly_q <= '0;
      ev_q       <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      dens_q     <= '0;
      tick_q     <= 1'b0;
      vh_q       <= '0;
      v_q        <= '0;
      st_q       <= S_IDLE;
      emg_q      <= 1'b0;
      er_q       <= 2'd0;
      ecnt_q     <= '0;
    end else begin
      deb_q      <= deb_d;
      dcnt_q     <= dcnt_d;
      loop_dly_q <= loop_dly_d;
      ev_q       <= ev_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      dens_q     <= dens_d;
      tick_q     <= tick_d;
      vh_q       <= vh_d;
      v_q        <= v_d;
      st_q       <= st_d;
      emg_q      <= emg_d;
      er_q       <= er_d;
      ecnt_q     <= ecnt_d;
    end
  end

  assign bus.TA          = dens_q[0];
  assign bus.TB          = dens_q[1];
  assign bus.TC          = dens_q[2];
  assign bus.TD          = dens_q[3];
  assign bus.VA          = v_q[0];
  assign bus.VB          = v_q[1];
  assign bus.VC          = v_q[2];
  assign bus.VD          = v_q[3];
  assign bus.emg_mode    = emg_q;
  assign bus.ER          = er_q;
  assign bus.window_tick = tick_q;

endmodule
